// File: rtl/uart_pixel_packer_pkg.sv
// Shared types and constants for the UART pixel packer: channel FSM states,
// pixel width and the byte-lane positions of R, G and B inside a pixel word.
package pixel_pkg;

  typedef enum logic [1:0] {
    S_R = 2'd0,
    S_G = 2'd1,
    S_B = 2'd2
  } pix_state_e;

  localparam int BYTE_W = 8;
  localparam int RGB_W  = 24;
  localparam int LANE_R = 2;
  localparam int LANE_G = 1;
  localparam int LANE_B = 0;

  // R lands in the most significant lane so that pi_data reads as {R,G,B}
  function automatic logic [RGB_W-1:0] pack_rgb(input logic [BYTE_W-1:0] r,
                                                 input logic [BYTE_W-1:0] g,
                                                 input logic [BYTE_W-1:0] b);
    logic [RGB_W-1:0] w;
    w = '0;
    w[LANE_R*BYTE_W +: BYTE_W] = r;
    w[LANE_G*BYTE_W +: BYTE_W] = g;
    w[LANE_B*BYTE_W +: BYTE_W] = b;
    return w;
  endfunction

endpackage

// File: rtl/uart_pixel_packer_if.sv
// Byte-in / pixel-out bundle between uart_rx, the packer and vga_pic.
// master drives bytes and observes pixels; slave is the packer itself.
interface uart_pixel_packer_if #(
  parameter int ADDR_W = 14
);
  logic [7:0]        po_data;
  logic              po_flag;
  logic [23:0]       pi_data;
  logic              pi_flag;
  logic [ADDR_W-1:0] pi_addr;
  logic              frame_done;
  logic              sync_err;

  modport master (
    output po_data, po_flag,
    input  pi_data, pi_flag, pi_addr, frame_done, sync_err
  );

  modport slave (
    input  po_data, po_flag,
    output pi_data, pi_flag, pi_addr, frame_done, sync_err
  );
endinterface

// File: rtl/uart_pixel_packer_byte_timeout.sv
// Idle-time counter: cleared by clr_i, otherwise counts clk cycles and
// saturates at T; expired_o is high while the count sits at T.
module byte_timeout #(
  parameter int T = 208320
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  output logic expired_o
);
  localparam int CNT_W = $clog2(T + 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (cnt_q != CNT_W'(T)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired_o = (cnt_q == CNT_W'(T));
endmodule

// File: rtl/uart_pixel_packer.sv
// Packs UART bytes R,G,B into 24-bit pixels with a wrapping frame-buffer address.
// Define PACK_TIMEOUT_EN to build the inter-byte timeout and sync_err pulse.
module uart_pixel_packer
  import pixel_pkg::*;
#(
  parameter int CLK_FREQ      = 50_000_000,
  parameter int UART_BPS      = 9600,
  parameter int PIX_NUM       = 10000,
  parameter int TIMEOUT_BYTES = 4
) (
  input logic                sys_clk,
  input logic                sys_rst,
  uart_pixel_packer_if.slave bus
);
  localparam int ADDR_W = $clog2(PIX_NUM);

  pix_state_e        state_q;
  logic [BYTE_W-1:0] r_q;
  logic [BYTE_W-1:0] g_q;
  logic [RGB_W-1:0]  pi_data_q;
  logic              pi_flag_q;
  logic [ADDR_W-1:0] pi_addr_q;
  logic              frame_done_q;
  logic [ADDR_W-1:0] wr_ptr_q;
  logic [ADDR_W-1:0] wr_ptr_d;
  logic              last_pix;

`ifdef PACK_TIMEOUT_EN
  localparam int T = TIMEOUT_BYTES * 10 * (CLK_FREQ / UART_BPS);

  logic expired;
  logic tmo_clr;
  logic sync_err_q;

  // Idle time only matters while a pixel is partially assembled
  assign tmo_clr = bus.po_flag || (state_q == S_R);

  byte_timeout #(
    .T(T)
  ) u_byte_timeout (
    .clk      (sys_clk),
    .rst      (sys_rst),
    .clr_i    (tmo_clr),
    .expired_o(expired)
  );

  assign bus.sync_err = sync_err_q;
`else
  assign bus.sync_err = 1'b0;
`endif

  assign last_pix = (wr_ptr_q == ADDR_W'(PIX_NUM - 1));
  assign wr_ptr_d = last_pix ? '0 : wr_ptr_q + 1'b1;

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state_q      <= S_R;
      r_q          <= '0;
      g_q          <= '0;
      pi_data_q    <= '0;
      pi_flag_q    <= 1'b0;
      pi_addr_q    <= '0;
      frame_done_q <= 1'b0;
      wr_ptr_q     <= '0;
`ifdef PACK_TIMEOUT_EN
      sync_err_q   <= 1'b0;
`endif
    end else begin
      pi_flag_q    <= 1'b0;
      frame_done_q <= 1'b0;
`ifdef PACK_TIMEOUT_EN
      sync_err_q   <= 1'b0;
`endif
      // A byte always wins over a timeout expiring in the same cycle
      if (bus.po_flag) begin
        case (state_q)
          S_R: begin
            r_q     <= bus.po_data;
            state_q <= S_G;
          end
          S_G: begin
            g_q     <= bus.po_data;
            state_q <= S_B;
          end
          S_B: begin
            pi_data_q    <= pack_rgb(r_q, g_q, bus.po_data);
            pi_addr_q    <= wr_ptr_q;
            pi_flag_q    <= 1'b1;
            frame_done_q <= last_pix;
            wr_ptr_q     <= wr_ptr_d;
            state_q      <= S_R;
          end
          default: state_q <= S_R;
        endcase
      end
`ifdef PACK_TIMEOUT_EN
      else if (expired && (state_q != S_R)) begin
        state_q    <= S_R;
        r_q        <= '0;
        g_q        <= '0;
        sync_err_q <= 1'b1;
      end
`endif
    end
  end

  assign bus.pi_data    = pi_data_q;
  assign bus.pi_flag    = pi_flag_q;
  assign bus.pi_addr    = pi_addr_q;
  assign bus.frame_done = frame_done_q;
endmodule
